uart_tx_fifo: RTL and testbench

//  Byte FIFO and issue sequencer between the CPU IO register file and the uart_lite TX port.
//  The IO block pushes one byte per write to UART0_TX_REG. This block buffers the bytes.
//  It hands each byte to uart_lite over the tx_rdy/tx_vld handshake, so firmware no longer

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo_mem.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART TX byte FIFO and the IO
//               register map: issue-sequencer state encoding, handshake
//               acknowledge timeout and the TX status register index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Issue sequencer states
    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_WAIT_ACK  = 2'd1,
        TXF_WAIT_DONE = 2'd2
    } txf_state_t;

    // Cycles tx_rdy may stay high after an issue pulse before the sequencer
    // concludes uart_lite took the byte without visibly going busy
    localparam int TXF_ACK_TIMEOUT = 2;

    // io_registers extension: FIFO status (full/empty/level/ovf) read-back
    localparam int UART0_TX_STAT_REG = 10;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_BITS storage with one write port and one
//               registered read port. The array itself has no reset so it
//               maps onto distributed RAM; only the read register is reset.
// Ports       : clk        system clock
//               i_rst_n    synchronous active-low reset (read register only)
//               i_wr_en    write strobe
//               i_wr_addr  write address
//               i_wr_data  write data
//               i_rd_en    read strobe, loads o_rd_data
//               i_rd_addr  read address
//               o_rd_data  registered read data, holds until next i_rd_en
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_BITS-1:0]     i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_BITS-1:0]     o_rd_data
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [DATA_BITS-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO plus issue sequencer between the IO register file
//               and the uart_lite TX port. Bytes pushed via wr_vld are
//               buffered and handed to uart_lite one at a time over the
//               tx_rdy/tx_vld handshake.
// Config      : `define UART_TX_FIFO_OVF_EN enables the sticky overflow flag;
//               otherwise ovf is tied low and ovf_clr is ignored.
// Ports       : clk      system clock
//               resetn   synchronous active-low reset
//               flush    drop all buffered bytes
//               wr_vld   push strobe          wr_data  byte to push
//               full     no free entry        empty    no buffered byte
//               level    buffered byte count, 0..DEPTH
//               tx_rdy   uart_lite ready      tx_vld   1-cycle issue pulse
//               tx_data  byte presented with tx_vld, held until next issue
//               ovf      sticky overflow      ovf_clr  clears ovf
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16    // power of 2, >= 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [DATA_BITS-1:0]   wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   tx_rdy,
    output logic                   tx_vld,
    output logic [DATA_BITS-1:0]   tx_data,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LVL_WL = AW + 1;

    localparam logic [1:0] S_IDLE      = TXF_IDLE;
    localparam logic [1:0] S_WAIT_ACK  = TXF_WAIT_ACK;
    localparam logic [1:0] S_WAIT_DONE = TXF_WAIT_DONE;

    localparam logic [1:0]  c_ACK_TIMEOUT = 2'(TXF_ACK_TIMEOUT);
    localparam logic [1:0]  c_CNT_ONE     = 2'd1;
    localparam logic [AW:0] c_PTR_ONE     = (AW+1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [LVL_WL-1:0] r_level;
    logic [1:0]        r_state;
    logic [1:0]        r_ack_cnt;
    logic              r_tx_vld;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // full is taken before any same-cycle pop, so a push on a full FIFO is
    // lost even while a byte leaves. flush overrides both push and pop.
    assign w_push = wr_vld && !w_full && !flush;
    assign w_pop  = (r_state == S_IDLE) && tx_rdy && !w_empty && !flush;

    // ------------------------------------------------------------------
    // Pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                r_level <= r_level + LVL_WL'(w_push) - LVL_WL'(w_pop);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue sequencer. The pulse cycle itself is spent in WAIT_ACK, so the
    // earliest next pulse is four cycles later on either exit path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_ack_cnt <= '0;
            r_tx_vld  <= 1'b0;
        end else begin
            r_tx_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_vld  <= 1'b1;
                        r_ack_cnt <= '0;
                        r_state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (!tx_rdy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_ack_cnt == c_ACK_TIMEOUT) begin
                        // uart_lite never showed busy: assume it took the byte
                        r_state <= S_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_rdy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The memory's read register doubles as the tx_data holding register
    sync_fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_rst_n   (resetn),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (tx_data)
    );

    // ------------------------------------------------------------------
    // Overflow flag
    // ------------------------------------------------------------------
`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // A new drop in the same cycle as ovf_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (wr_vld && w_full && !flush) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused;

    assign w_unused = ovf_clr;
    assign ovf      = 1'b0;
`endif

    assign full   = w_full;
    assign empty  = w_empty;
    assign level  = r_level;
    assign tx_vld = r_tx_vld;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo. Accepted bytes
//               are queued as expectations; a monitor captures every tx_vld
//               pulse and the directed sequence compares them in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic       wr_vld;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       tx_rdy;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       ovf;
    logic       ovf_clr;

    // tx_rdy source: either directly driven or a small uart_lite model
    logic auto_uart  = 1'b0;
    logic manual_rdy = 1'b0;
    logic uart_rdy   = 1'b1;
    int   busy       = 0;

    assign tx_rdy = auto_uart ? uart_rdy : manual_rdy;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int dbl_cnt = 0;
    logic prev_vld = 1'b0;

    logic [7:0] sbq  [$];   // expected bytes, in push order
    logic [7:0] obsq [$];   // bytes seen with tx_vld
    int         obs_t[$];   // cycle number of each pulse

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .wr_vld  (wr_vld),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_rdy  (tx_rdy),
        .tx_vld  (tx_vld),
        .tx_data (tx_data),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    // uart_lite model: goes busy one cycle after a pulse, for three cycles
    always @(negedge clk) begin
        if (!auto_uart) begin
            busy     = 0;
            uart_rdy = 1'b1;
        end else if (busy > 0) begin
            busy     = busy - 1;
            uart_rdy = (busy == 0);
        end else if (tx_vld === 1'b1) begin
            busy = 4;
        end
    end

    // Output monitor
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_vld === 1'b1) begin
            obsq.push_back(tx_data);
            obs_t.push_back(cyc);
            if (prev_vld) dbl_cnt = dbl_cnt + 1;
        end
        prev_vld = (tx_vld === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        wr_vld  = 1'b1;
        wr_data = b;
        if (keep) sbq.push_back(b);
        @(negedge clk);
        wr_vld  = 1'b0;
    endtask

    // Wait (bounded) for n pulses, then compare them against the scoreboard
    task automatic drain(input string tag, input int n);
        int t;
        logic [7:0] exp_b;
        t = 0;
        while (obsq.size() < n && t < 300) begin
            @(negedge clk);
            t = t + 1;
        end
        check($sformatf("%s pulse count", tag), obsq.size(), n);
        for (int i = 0; i < n; i++) begin
            if (obsq.size() == 0) break;
            if (sbq.size() != 0) exp_b = sbq.pop_front();
            else                 exp_b = 8'hEE;
            check($sformatf("%s byte%0d", tag, i), obsq.pop_front(), exp_b);
        end
    endtask

    initial begin
        resetn  = 1'b0;
        flush   = 1'b0;
        wr_vld  = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        check("rst empty",   empty,   1);
        check("rst full",    full,    0);
        check("rst level",   level,   0);
        check("rst tx_vld",  tx_vld,  0);
        check("rst tx_data", tx_data, 0);
        check("rst ovf",     ovf,     0);
        resetn = 1'b1;
        tick(2);

        // ---------------- 1: three bytes in order ----------------
        auto_uart = 1'b1;
        push(8'h41, 1);
        push(8'h42, 1);
        push(8'h43, 1);
        drain("t1", 3);
        tick(10);
        check("t1 empty", empty, 1);
        check("t1 level", level, 0);

        // ---------------- 2: fill, overflow, drain ----------------
        auto_uart  = 1'b0;
        manual_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i), 1);
        check("t2 full",  full,  1);
        check("t2 level", level, 16);
        push(8'hFF, 0);
`ifdef UART_TX_FIFO_OVF_EN
        check("t2 ovf", ovf, 1);
`else
        check("t2 ovf", ovf, 0);
`endif
        check("t2 level after drop", level, 16);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t2 ovf cleared", ovf, 0);
        auto_uart = 1'b1;
        drain("t2", 16);
        tick(10);
        check("t2 empty", empty, 1);

        // ---------------- 3: simultaneous push/pop ----------------
        auto_uart  = 1'b0;
        manual_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1);
        check("t3 level full", level, 16);
        manual_rdy = 1'b1;
        push(8'h99, 0);
        manual_rdy = 1'b0;
        check("t3 level after full push+pop", level, 15);
        check("t3 not full", full, 0);
        auto_uart = 1'b1;
        drain("t3a", 16);
        tick(10);
        auto_uart  = 1'b0;
        manual_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1);
        check("t3 level half", level, 8);
        manual_rdy = 1'b1;
        push(8'hA8, 1);
        manual_rdy = 1'b0;
        check("t3 level after half push+pop", level, 8);
        auto_uart = 1'b1;
        drain("t3b", 9);
        tick(10);

        // ---------------- 4: tx_rdy never drops ----------------
        auto_uart  = 1'b0;
        manual_rdy = 1'b1;
        obs_t.delete();
        push(8'h51, 1);
        push(8'h52, 1);
        tick(20);
        drain("t4", 2);
        check("t4 pulse times", obs_t.size(), 2);
        if (obs_t.size() >= 2) check("t4 pulse gap", obs_t[1] - obs_t[0], 4);
        tick(10);
        check("t4 no extra pulse", obsq.size(), 0);

        // ---------------- 5: flush with byte in flight ----------------
        manual_rdy = 1'b0;
        tick(2);
        push(8'h61, 1);
        for (int i = 2; i <= 5; i++) push(8'h60 + 8'(i), 0);
        check("t5 level 5", level, 5);
        manual_rdy = 1'b1;
        tick(1);
        manual_rdy = 1'b0;
        check("t5 issued", tx_vld, 1);
        check("t5 level 4", level, 4);
        tick(1);
        flush = 1'b1;
        push(8'h66, 0);
        flush = 1'b0;
        check("t5 flush level", level, 0);
        check("t5 flush empty", empty, 1);
        manual_rdy = 1'b1;
        tick(20);
        drain("t5", 1);
        check("t5 no further pulse", obsq.size(), 0);

        // ---------------- 6: reset in WAIT_DONE ----------------
        manual_rdy = 1'b0;
        tick(2);
        push(8'h71, 1);
        push(8'h72, 0);
        push(8'h73, 0);
        push(8'h74, 0);
        manual_rdy = 1'b1;
        tick(1);
        manual_rdy = 1'b0;
        tick(2);
        check("t6 level 3", level, 3);
        resetn = 1'b0;
        tick(1);
        check("t6 rst tx_vld",  tx_vld,  0);
        check("t6 rst tx_data", tx_data, 0);
        check("t6 rst level",   level,   0);
        check("t6 rst empty",   empty,   1);
        check("t6 rst full",    full,    0);
        check("t6 rst ovf",     ovf,     0);
        resetn     = 1'b1;
        manual_rdy = 1'b1;
        tick(10);
        check("t6 quiet after reset", obsq.size(), 1);
        push(8'h77, 1);
        tick(10);
        drain("t6", 2);

        check("no double pulse", dbl_cnt, 0);
        check("scoreboard empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
